beat_sequencer: RTL

- Replaces the free-running divided play clock and the ad-hoc beat counter with a single-clock sequencer for the music datapath.
- Owns transport state (stop/play/pause), tempo level, and A–B loop capture.
- Emits the beat index `ibeat` consumed by the music ROM/tone lookup, plus a one-cycle `beat_tick` enable.
- Runs entirely on `clk`; no derived clocks. Button inputs arrive already debounced and one-pulsed.

---
 rtl/music_pkg.sv | 30 +++
 rtl/beat_sequencer_if.sv | 28 ++
 rtl/beat_timer.sv | 25 ++
 rtl/beat_sequencer.sv | 129 ++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - shared transport state, tempo and loop-size constants for the music datapath
package music_pkg;

   typedef enum logic [1:0] {
      STOP  = 2'd0,
      PLAY  = 2'd1,
      PAUSE = 2'd2
   } state_t;

   localparam logic [2:0] SPEED_MIN     = 3'd0;
   localparam logic [2:0] SPEED_MAX     = 3'd4;
   localparam logic [2:0] SPEED_DEFAULT = 3'd2;

   localparam logic [2:0] LOOP_W_MIN      = 3'd2;
   localparam logic [2:0] LOOP_W_MAX      = 3'd6;
   localparam int         BEATS_PER_WIDTH = 4;

   // Loop length in beats for a raw width selector; out-of-range selectors clamp.
   function automatic logic [4:0] loop_len(input logic [2:0] w);
      logic [2:0] c;
      if (w < LOOP_W_MIN)
         c = LOOP_W_MIN;
      else if (w > LOOP_W_MAX)
         c = LOOP_W_MAX;
      else
         c = w;
      return 5'(int'(c) * BEATS_PER_WIDTH);
   endfunction

endpackage

// File: rtl/beat_sequencer_if.sv
// rtl/beat_sequencer_if.sv - control pulses in, beat index and transport status out
interface beat_sequencer_if #(
   parameter int BEAT_W = 12
);
   logic              play_toggle;
   logic              restart;
   logic              speed_up;
   logic              speed_down;
   logic              loop_req;
   logic [2:0]        loop_width;
   logic [BEAT_W-1:0] ibeat;
   logic              beat_tick;
   logic              playing;
   logic              looping;
   logic [2:0]        speed;
   logic [BEAT_W-1:0] loop_start;
   logic [BEAT_W-1:0] loop_end;

   modport master (
      output play_toggle, restart, speed_up, speed_down, loop_req, loop_width,
      input  ibeat, beat_tick, playing, looping, speed, loop_start, loop_end
   );

   modport slave (
      input  play_toggle, restart, speed_up, speed_down, loop_req, loop_width,
      output ibeat, beat_tick, playing, looping, speed, loop_start, loop_end
   );
endinterface

// File: rtl/beat_timer.sv
// rtl/beat_timer.sv - beat-period counter with enable, clear and terminal-count pulse
module beat_timer #(
   parameter int CNT_W = 26
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [CNT_W-1:0] period,
   output logic             tc
);
   logic [CNT_W-1:0] cnt_q;

   // Terminal count is judged on the current period, so a clear in the same cycle still ticks.
   assign tc = en && (cnt_q == period - CNT_W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else if (clr || tc)
         cnt_q <= '0;
      else if (en)
         cnt_q <= cnt_q + CNT_W'(1);
   end
endmodule

// File: rtl/beat_sequencer.sv
// rtl/beat_sequencer.sv - transport FSM, tempo, A-B loop capture and beat index generation
module beat_sequencer
   import music_pkg::*;
#(
   parameter int LEN         = 64,
   parameter int BEAT_W      = 12,
   parameter int BASE_PERIOD = 12_500_000,
   parameter int CNT_W       = 26
) (
   input  logic              clk,
   input  logic              rst,
   beat_sequencer_if.slave   bus
);
   localparam int                SUM_W = BEAT_W + 1;
   localparam logic [BEAT_W-1:0] LAST  = BEAT_W'(LEN - 1);
   localparam logic [CNT_W-1:0]  P_MAX = CNT_W'(BASE_PERIOD * 4);

   state_t            state_q, state_nx;
   logic [2:0]        speed_q, speed_nx;
   logic              speed_chg;
   logic [CNT_W-1:0]  period;
   logic              tc;
   logic              timer_en, timer_clr;
   logic [BEAT_W-1:0] ibeat_q, next_beat;
   logic              beat_tick_q, playing_q, looping_q, loop_req_q;
   logic [BEAT_W-1:0] loop_start_q, loop_end_q, cap_end;
   logic [SUM_W-1:0]  cap_sum;
   logic              capture;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= STOP;
      else
         state_q <= state_nx;
   end

   always_comb begin
      state_nx = state_q;
      if (bus.restart)
         state_nx = STOP;
      else if (bus.play_toggle) begin
         case (state_q)
            STOP:    state_nx = PLAY;
            PLAY:    state_nx = PAUSE;
            PAUSE:   state_nx = PLAY;
            default: state_nx = STOP;
         endcase
      end
   end

   // Simultaneous up/down cancels; a saturated request is not a change and keeps the counter.
   always_comb begin
      speed_nx  = speed_q;
      speed_chg = 1'b0;
      if (bus.speed_up && !bus.speed_down && speed_q < SPEED_MAX) begin
         speed_nx  = speed_q + 3'd1;
         speed_chg = 1'b1;
      end else if (bus.speed_down && !bus.speed_up && speed_q > SPEED_MIN) begin
         speed_nx  = speed_q - 3'd1;
         speed_chg = 1'b1;
      end
   end

   assign period    = P_MAX >> speed_q;
   assign timer_en  = (state_q == PLAY);
   assign timer_clr = bus.restart || speed_chg;

   beat_timer #(.CNT_W(CNT_W)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .en     (timer_en),
      .clr    (timer_clr),
      .period (period),
      .tc     (tc)
   );

   always_comb begin
      next_beat = ibeat_q + BEAT_W'(1);
      if (looping_q && ibeat_q == loop_end_q)
         next_beat = loop_start_q;
      else if (ibeat_q == LAST)
         next_beat = '0;
   end

   assign capture = bus.loop_req && !loop_req_q && (state_q != STOP) && !bus.restart;
   assign cap_sum = {1'b0, ibeat_q} + SUM_W'(loop_len(bus.loop_width)) - SUM_W'(1);
   assign cap_end = (cap_sum > {1'b0, LAST}) ? LAST : cap_sum[BEAT_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ibeat_q      <= '0;
         beat_tick_q  <= 1'b0;
         playing_q    <= 1'b0;
         looping_q    <= 1'b0;
         loop_req_q   <= 1'b0;
         speed_q      <= SPEED_DEFAULT;
         loop_start_q <= '0;
         loop_end_q   <= '0;
      end else begin
         speed_q     <= speed_nx;
         loop_req_q  <= bus.loop_req;
         playing_q   <= (state_nx == PLAY);
         beat_tick_q <= tc && !bus.restart;
         if (bus.restart) begin
            ibeat_q   <= '0;
            looping_q <= 1'b0;
         end else begin
            if (tc)
               ibeat_q <= next_beat;
            // Capture samples the pre-tick beat even when a tick lands in the same cycle.
            if (capture) begin
               loop_start_q <= ibeat_q;
               loop_end_q   <= cap_end;
               looping_q    <= 1'b1;
            end else if (!bus.loop_req) begin
               looping_q <= 1'b0;
            end
         end
      end
   end

   assign bus.ibeat      = ibeat_q;
   assign bus.beat_tick  = beat_tick_q;
   assign bus.playing    = playing_q;
   assign bus.looping    = looping_q;
   assign bus.speed      = speed_q;
   assign bus.loop_start = loop_start_q;
   assign bus.loop_end   = loop_end_q;
endmodule
